// File: rtl/lsnn_pkg.sv
// Shared types, default constants and arithmetic helpers for the LSNN neuron array.
package lsnn_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_W_IN            = 8;
  localparam int DEF_W_MEM           = 12;
  localparam int DEF_LEAK_SHIFT      = 3;
  localparam int DEF_THR_BASE        = 200;
  localparam int DEF_THR_INC         = 64;
  localparam int DEF_THR_MAX         = 1000;
  localparam int DEF_THR_DECAY_SHIFT = 4;
  localparam int DEF_REFRAC          = 2;
  localparam int DEF_RESET_MODE      = 0;

  // Unsigned add clamped to 2^w-1; operands are assumed to already fit in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsnn_neuron_update.sv
// Combinational next-state of one adaptive-threshold LIF neuron: (m, h, r, current) -> (m', h', r', spike).
module lsnn_neuron_update
  import lsnn_pkg::*;
#(
  parameter int W_IN            = DEF_W_IN,
  parameter int W_MEM           = DEF_W_MEM,
  parameter int LEAK_SHIFT      = DEF_LEAK_SHIFT,
  parameter int THR_BASE        = DEF_THR_BASE,
  parameter int THR_INC         = DEF_THR_INC,
  parameter int THR_MAX         = DEF_THR_MAX,
  parameter int THR_DECAY_SHIFT = DEF_THR_DECAY_SHIFT,
  parameter int REFRAC          = DEF_REFRAC,
  parameter int RESET_MODE      = DEF_RESET_MODE,
  parameter int R_W             = cnt_width(DEF_REFRAC)
) (
  input  logic [W_MEM-1:0] m,
  input  logic [W_MEM-1:0] h,
  input  logic [R_W-1:0]   r,
  input  logic [W_IN-1:0]  current,
  output logic [W_MEM-1:0] m_next,
  output logic [W_MEM-1:0] h_next,
  output logic [R_W-1:0]   r_next,
  output logic             spike
);

  localparam logic [W_MEM-1:0] BASE = W_MEM'(THR_BASE);
  localparam logic [W_MEM-1:0] MAXT = W_MEM'(THR_MAX);
  localparam logic [W_MEM:0]   INC  = (W_MEM+1)'(THR_INC);

  logic [W_MEM-1:0] leaked;
  logic [W_MEM-1:0] m_sum;
  logic [W_MEM-1:0] diff;
  logic [W_MEM-1:0] step;
  logic [W_MEM-1:0] h_relax;
  logic [W_MEM-1:0] h_up;
  logic [W_MEM:0]   h_inc;

  // Threshold relaxes toward BASE by at least one per update, so it always settles exactly on BASE.
  always_comb begin
    leaked  = m - (m >> LEAK_SHIFT);
    m_sum   = W_MEM'(sat_add(32'(leaked), 32'(current), W_MEM));
    diff    = h - BASE;
    step    = diff >> THR_DECAY_SHIFT;
    if (step == '0) step = W_MEM'(1);
    h_relax = (h > BASE) ? h - step : h;
    h_inc   = {1'b0, h} + INC;
    h_up    = (h_inc > {1'b0, MAXT}) ? MAXT : h_inc[W_MEM-1:0];

    spike  = 1'b0;
    m_next = m_sum;
    h_next = h_relax;
    r_next = '0;
    if (r != '0) begin
      m_next = '0;
      r_next = r - R_W'(1);
    end else if (m_sum >= h) begin
      spike  = 1'b1;
      m_next = (RESET_MODE != 0) ? m_sum - h : '0;
      h_next = h_up;
      r_next = R_W'(REFRAC);
    end
  end

endmodule

// File: rtl/lsnn_array.sv
// Time-multiplexed array of adaptive-threshold LIF neurons, one channel updated per accepted beat.
module lsnn_array
  import lsnn_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int W_IN            = DEF_W_IN,
  parameter int W_MEM           = DEF_W_MEM,
  parameter int LEAK_SHIFT      = DEF_LEAK_SHIFT,
  parameter int THR_BASE        = DEF_THR_BASE,
  parameter int THR_INC         = DEF_THR_INC,
  parameter int THR_MAX         = DEF_THR_MAX,
  parameter int THR_DECAY_SHIFT = DEF_THR_DECAY_SHIFT,
  parameter int REFRAC          = DEF_REFRAC,
  parameter int RESET_MODE      = DEF_RESET_MODE,
  localparam int CH_W           = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [W_IN-1:0]  in_current,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_spike,
  output logic [W_MEM-1:0] out_mem,
  output logic [W_MEM-1:0] out_thr
);

  localparam int               R_W     = cnt_width(REFRAC);
  localparam logic [CH_W:0]    N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
  localparam logic [W_MEM-1:0] BASE    = W_MEM'(THR_BASE);

  state_t            state;
  state_t            state_next;
  logic [CH_W-1:0]   clr_idx;
  logic              clearing;
  logic              accept;
  logic              ch_ok;
  logic              update;
  logic [CH_W-1:0]   sel;

  logic [W_MEM-1:0]  mem    [N_CH];
  logic [W_MEM-1:0]  thr    [N_CH];
  logic [R_W-1:0]    refrac [N_CH];

  logic [W_MEM-1:0]  m_next;
  logic [W_MEM-1:0]  h_next;
  logic [R_W-1:0]    r_next;
  logic              spike;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr) state_next = CLEAR;
      CLEAR:   if (clr_idx == LAST_CH) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    clearing = 1'b0;
    case (state)
      IDLE:    in_ready = ~clr;
      CLEAR:   clearing = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           clr_idx <= '0;
    else if (clearing) clr_idx <= clr_idx + CH_W'(1);
    else               clr_idx <= '0;
  end

  // Out-of-range channels are still accepted so the stream never stalls, but they touch nothing.
  assign accept = in_valid & in_ready;
  assign ch_ok  = ({1'b0, in_ch} < N_CH_L);
  assign update = accept & ch_ok;
  assign sel    = ch_ok ? in_ch : '0;

  lsnn_neuron_update #(
    .W_IN            (W_IN),
    .W_MEM           (W_MEM),
    .LEAK_SHIFT      (LEAK_SHIFT),
    .THR_BASE        (THR_BASE),
    .THR_INC         (THR_INC),
    .THR_MAX         (THR_MAX),
    .THR_DECAY_SHIFT (THR_DECAY_SHIFT),
    .REFRAC          (REFRAC),
    .RESET_MODE      (RESET_MODE),
    .R_W             (R_W)
  ) u_update (
    .m       (mem[sel]),
    .h       (thr[sel]),
    .r       (refrac[sel]),
    .current (in_current),
    .m_next  (m_next),
    .h_next  (h_next),
    .r_next  (r_next),
    .spike   (spike)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        mem[k]    <= '0;
        thr[k]    <= BASE;
        refrac[k] <= '0;
      end
    end else if (clearing) begin
      mem[clr_idx]    <= '0;
      thr[clr_idx]    <= BASE;
      refrac[clr_idx] <= '0;
    end else if (update) begin
      mem[sel]    <= m_next;
      thr[sel]    <= h_next;
      refrac[sel] <= r_next;
    end
  end

  // Result fields hold their last values between updates; only out_valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_spike <= 1'b0;
      out_mem   <= '0;
      out_thr   <= '0;
    end else begin
      out_valid <= update;
      if (update) begin
        out_ch    <= sel;
        out_spike <= spike;
        out_mem   <= m_next;
        out_thr   <= thr[sel];
      end
    end
  end

endmodule

// File: tb/tb_lsnn_array.sv
// Self-checking bench: four lsnn_array configurations share one stimulus stream, checked against a plain-arithmetic model.
module tb_lsnn_array;

  localparam int NI = 4;

  logic clk;
  logic rst;
  logic clr;
  logic in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_current;

  logic        rdy  [NI];
  logic        ov   [NI];
  logic [1:0]  och  [NI];
  logic        osp  [NI];
  logic [11:0] omem [NI];
  logic [11:0] othr [NI];

  // Instance configs: 0 default, 1 subtractive reset, 2 no-leak saturation probe, 3 three channels.
  int cfg_nch  [NI] = '{4, 4, 4, 3};
  int cfg_ls   [NI] = '{3, 3, 12, 3};
  int cfg_base [NI] = '{200, 200, 4095, 200};
  int cfg_max  [NI] = '{1000, 1000, 4095, 1000};
  int cfg_rm   [NI] = '{0, 1, 0, 0};

  lsnn_array dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ch(in_ch), .in_current(in_current), .out_valid(ov[0]), .out_ch(och[0]),
    .out_spike(osp[0]), .out_mem(omem[0]), .out_thr(othr[0]));

  lsnn_array #(.RESET_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ch(in_ch), .in_current(in_current), .out_valid(ov[1]), .out_ch(och[1]),
    .out_spike(osp[1]), .out_mem(omem[1]), .out_thr(othr[1]));

  lsnn_array #(.THR_BASE(4095), .THR_MAX(4095), .LEAK_SHIFT(12)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_ch(in_ch), .in_current(in_current), .out_valid(ov[2]), .out_ch(och[2]),
    .out_spike(osp[2]), .out_mem(omem[2]), .out_thr(othr[2]));

  lsnn_array #(.N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_ch(in_ch), .in_current(in_current), .out_valid(ov[3]), .out_ch(och[3]),
    .out_spike(osp[3]), .out_mem(omem[3]), .out_thr(othr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mm [NI][4];
  int mh [NI][4];
  int mr [NI][4];
  int clr_left [NI];
  int e_valid [NI];
  int e_ch    [NI];
  int e_spike [NI];
  int e_mem   [NI];
  int e_thr   [NI];
  logic rdy_seen;

  typedef struct {
    bit rst_first;
    int ch;
    int cur;
    int spike;
    int mem;
    int thr;
  } vec_t;

  vec_t tbl [12];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 4; c++) begin
        mm[i][c] = 0;
        mh[i][c] = cfg_base[i];
        mr[i][c] = 0;
      end
      clr_left[i] = 0;
      e_valid[i] = 0; e_ch[i] = 0; e_spike[i] = 0; e_mem[i] = 0; e_thr[i] = 0;
    end
  endtask

  task automatic modelUpdate(input int i, input int ch, input int cur);
    int h, relaxed, mp;
    if (ch >= cfg_nch[i]) begin
      e_valid[i] = 0;
      return;
    end
    h = mh[i][ch];
    e_valid[i] = 1;
    e_ch[i]    = ch;
    e_thr[i]   = h;
    e_spike[i] = 0;
    relaxed = h;
    if (h > cfg_base[i]) relaxed = h - (((h - cfg_base[i]) / 16 > 1) ? (h - cfg_base[i]) / 16 : 1);
    if (mr[i][ch] > 0) begin
      mm[i][ch] = 0;
      mr[i][ch] = mr[i][ch] - 1;
      mh[i][ch] = relaxed;
    end else begin
      mp = mm[i][ch] - mm[i][ch] / (1 << cfg_ls[i]) + cur;
      if (mp > 4095) mp = 4095;
      if (mp >= h) begin
        e_spike[i] = 1;
        mm[i][ch] = (cfg_rm[i] != 0) ? mp - h : 0;
        mh[i][ch] = (h + 64 < cfg_max[i]) ? h + 64 : cfg_max[i];
        mr[i][ch] = 2;
      end else begin
        mm[i][ch] = mp;
        mh[i][ch] = relaxed;
      end
    end
    e_mem[i] = mm[i][ch];
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("inst%0d out_valid", i), 32'(ov[i]),   32'(e_valid[i]));
      cmp($sformatf("inst%0d out_ch", i),    32'(och[i]),  32'(e_ch[i]));
      cmp($sformatf("inst%0d out_spike", i), 32'(osp[i]),  32'(e_spike[i]));
      cmp($sformatf("inst%0d out_mem", i),   32'(omem[i]), 32'(e_mem[i]));
      cmp($sformatf("inst%0d out_thr", i),   32'(othr[i]), 32'(e_thr[i]));
    end
  endtask

  // Entered and left one time unit after a rising edge; one call is one clock cycle.
  task automatic applyStimulus(input bit v, input int ch, input int cur, input bit c);
    in_valid   = v;
    in_ch      = 2'(ch);
    in_current = 8'(cur);
    clr        = c;
    #1;
    rdy_seen = rdy[0];
    for (int i = 0; i < NI; i++)
      cmp($sformatf("inst%0d in_ready", i), 32'(rdy[i]), 32'((clr_left[i] == 0) && !c));
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (clr_left[i] > 0) begin
        clr_left[i]--;
        e_valid[i] = 0;
      end else if (c) begin
        for (int k = 0; k < 4; k++) begin
          mm[i][k] = 0; mh[i][k] = cfg_base[i]; mr[i][k] = 0;
        end
        clr_left[i] = cfg_nch[i];
        e_valid[i] = 0;
      end else if (v) begin
        modelUpdate(i, ch, cur);
      end else begin
        e_valid[i] = 0;
      end
    end
    #1;
    checkOutput();
  endtask

  // Asserts rst between edges with a beat still on the inputs; outputs must clear without waiting for a clock.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows;
    tbl[0]  = '{1, 0, 100, 0, 100, 200};
    tbl[1]  = '{0, 0, 100, 0, 188, 200};
    tbl[2]  = '{0, 0, 100, 1,   0, 200};
    tbl[3]  = '{0, 0, 100, 0,   0, 264};
    tbl[4]  = '{0, 0, 100, 0,   0, 260};
    tbl[5]  = '{0, 0, 100, 0, 100, 257};
    tbl[6]  = '{1, 0, 100, 0, 100, 200};
    tbl[7]  = '{0, 1,  50, 0,  50, 200};
    tbl[8]  = '{0, 0, 100, 0, 188, 200};
    tbl[9]  = '{0, 2,   7, 0,   7, 200};
    tbl[10] = '{0, 3,   9, 0,   9, 200};
    tbl[11] = '{0, 0, 100, 1,   0, 200};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = 2'd0; in_current = 8'd0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    $display("[TB] directed table: spike, refractory, interleaving");
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].rst_first) doReset();
      applyStimulus(1'b1, tbl[k].ch, tbl[k].cur, 1'b0);
      cmp($sformatf("tbl%0d valid", k), 32'(ov[0]), 32'd1);
      cmp($sformatf("tbl%0d ch", k),    32'(och[0]), 32'(tbl[k].ch));
      cmp($sformatf("tbl%0d spike", k), 32'(osp[0]), 32'(tbl[k].spike));
      cmp($sformatf("tbl%0d mem", k),   32'(omem[0]), 32'(tbl[k].mem));
      cmp($sformatf("tbl%0d thr", k),   32'(othr[0]), 32'(tbl[k].thr));
      if (k == 2) cmp("reset_mode1 spike mem", 32'(omem[1]), 32'd65);
    end

    $display("[TB] clear sweep after spike");
    applyStimulus(1'b1, 0, 100, 1'b1);
    cmp("clr cycle out_valid", 32'(ov[0]), 32'd0);
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 0, 0, (k == 1));
      if (!rdy_seen) lows++;
    end
    cmp("clear sweep ready-low cycles", 32'(lows), 32'd4);
    applyStimulus(1'b1, 0, 100, 1'b0);
    cmp("post-clear mem", 32'(omem[0]), 32'd100);
    cmp("post-clear thr", 32'(othr[0]), 32'd200);

    $display("[TB] dropped beat on out-of-range channel");
    applyStimulus(1'b1, 3, 77, 1'b0);
    cmp("n3 ch3 dropped", 32'(ov[3]), 32'd0);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 1, 30, 1'b0);
    doReset();
    applyStimulus(1'b1, 0, 100, 1'b0);
    cmp("post-rst mem", 32'(omem[0]), 32'd100);

    $display("[TB] saturation under sustained input");
    doReset();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 0, 255, 1'b0);
      if (k == 15) cmp("sat pre-limit mem", 32'(omem[2]), 32'd4080);
      if (k == 16) begin
        cmp("sat spike", 32'(osp[2]), 32'd1);
        cmp("sat thr", 32'(othr[2]), 32'd4095);
      end
    end

    $display("[TB] randomized stream");
    for (int k = 0; k < 500; k++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
                    $urandom_range(0, 49) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
